// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and word encoding for the read-stream block and the buffer it drains.
package fifo_rd_stream_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_t;

    // One buffered word: nucleotide in the top two bits, quality score below.
    typedef struct packed {
        base_t                    base;
        logic [DEF_DATA_WIDTH-3:0] score;
    } base_word_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundle of buffer-side and stream-side signals around the read-stream block.
interface fifo_rd_stream_if
    import fifo_rd_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  clr;
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overflow;

    modport master (
        input  clr, wr, rd_data, m_ready,
        output rd, m_valid, m_data, count, empty, full, overflow
    );

    modport slave (
        output clr, wr, rd_data, m_ready,
        input  rd, m_valid, m_data, count, empty, full, overflow
    );

endinterface

// File: rtl/skid_queue2.sv
// Two-entry FIFO catching registered memory read data ahead of the output stream.
module skid_queue2
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] entry0_q;
    logic [DATA_WIDTH-1:0] entry1_q;
    logic [1:0]            occ_q;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop && (occ_q != 2'd0);
    assign do_push = push && ((occ_q != 2'd2) || do_pop);

    // entry0 is always the head; a pop shifts entry1 forward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry0_q <= '0;
            entry1_q <= '0;
            occ_q    <= 2'd0;
        end else if (clr) begin
            entry0_q <= '0;
            entry1_q <= '0;
            occ_q    <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        entry0_q <= push_data;
                    end else begin
                        entry1_q <= push_data;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    entry0_q <= entry1_q;
                    occ_q    <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        entry0_q <= push_data;
                    end else begin
                        entry0_q <= entry1_q;
                        entry1_q <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head      = entry0_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a buffer with a registered read port into a valid/ready stream,
// tracking occupancy from writer pushes and its own pops.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    fifo_rd_stream_if.master bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   count_q;
    logic                  overflow_q;
    logic                  in_flight_q;
    logic [1:0]            occupancy;
    logic [1:0]            credits_used;
    logic [DATA_WIDTH-1:0] head;
    logic                  empty_int;
    logic                  full_int;
    logic                  pop;
    logic                  rd_int;
    logic                  wr_accept;

    assign empty_int    = (count_q == '0);
    assign full_int     = (count_q == DEPTH);
    assign pop          = (occupancy != 2'd0) && bus.m_ready;
    assign credits_used = occupancy + {1'b0, in_flight_q};

    // Queue slots plus the word in flight form two credits; a same-cycle pop frees one.
    always_comb begin
        rd_int = 1'b0;
        if (!bus.clr && !empty_int) begin
            if (credits_used < 2'd2) begin
                rd_int = 1'b1;
            end else if ((credits_used == 2'd2) && pop) begin
                rd_int = 1'b1;
            end
        end
    end

    assign wr_accept = bus.wr && (!full_int || rd_int);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            in_flight_q <= 1'b0;
        end else if (bus.clr) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= rd_int;
            if (bus.wr && full_int && !rd_int) begin
                overflow_q <= 1'b1;
            end
            case ({wr_accept, rd_int})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Clearing in_flight on clr is what drops the read data still arriving.
    skid_queue2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .clr       (bus.clr),
        .push      (in_flight_q),
        .push_data (bus.rd_data),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy)
    );

    assign bus.rd       = rd_int;
    assign bus.m_valid  = (occupancy != 2'd0);
    assign bus.m_data   = head;
    assign bus.count    = count_q;
    assign bus.empty    = empty_int;
    assign bus.full     = full_int;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: models the buffer memory's registered read port and checks the stream side.
module tb_fifo_rd_stream;
    import fifo_rd_stream_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] mem [16];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    int            errors;
    int            checks;

    fifo_rd_stream_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

    fifo_rd_stream #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the pointer controller and memory: write on accepted wr, registered read on rd.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp          <= '0;
            rp          <= '0;
            ifc.rd_data <= '0;
        end else if (ifc.clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (ifc.wr && (!ifc.full || ifc.rd)) begin
                mem[wp] <= wr_data;
                wp      <= wp + 1'b1;
            end
            if (ifc.rd) begin
                ifc.rd_data <= mem[rp];
                rp          <= rp + 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic rdy, input logic c);
        ifc.wr      = w;
        wr_data     = d;
        ifc.m_ready = rdy;
        ifc.clr     = c;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic singleWord();
        base_word_t word;
        word = '{base: BASE_C, score: 6'd1};
        applyStimulus(1'b1, word, 1'b1, 1'b0);
        checkOutput("sw_no_bypass", ifc.rd, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("sw_rd_c1", ifc.rd, 1'b1);
        checkOutput("sw_count_c1", ifc.count, 32'd1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("sw_empty_c2", ifc.empty, 1'b1);
        checkOutput("sw_valid_c2", ifc.m_valid, 1'b0);
        checkOutput("sw_rd_c2", ifc.rd, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("sw_valid_c3", ifc.m_valid, 1'b1);
        checkOutput("sw_data_c3", ifc.m_data, 32'h41);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("sw_drained", ifc.m_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int rd_cnt, rd_first, rd_last, out_idx, v_first, v_last, spurious;
        logic [DW-1:0] exp_data;

        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        ifc.clr = 1'b0;
        ifc.wr  = 1'b0;
        ifc.m_ready = 1'b0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_count", ifc.count, 32'd0);
        checkOutput("rst_empty", ifc.empty, 1'b1);
        checkOutput("rst_full", ifc.full, 1'b0);
        checkOutput("rst_overflow", ifc.overflow, 1'b0);
        checkOutput("rst_valid", ifc.m_valid, 1'b0);
        checkOutput("rst_data", ifc.m_data, 32'h0);
        checkOutput("rst_rd", ifc.rd, 1'b0);
        reset = 1'b1;

        $display("[TB] single word");
        singleWord();

        $display("[TB] burst of 16");
        rd_cnt = 0; rd_first = -1; rd_last = -1;
        out_idx = 0; v_first = -1; v_last = -1;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(c < 16, 8'h10 + 8'(c), 1'b1, 1'b0);
            if (ifc.rd) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = c;
                rd_last = c;
            end
            if (ifc.m_valid) begin
                exp_data = 8'h10 + 8'(out_idx);
                checkOutput("burst_data", ifc.m_data, exp_data);
                out_idx++;
                if (v_first < 0) v_first = c;
                v_last = c;
            end
            step();
        end
        checkOutput("burst_words", out_idx, 32'd16);
        checkOutput("burst_rd_pulses", rd_cnt, 32'd16);
        checkOutput("burst_rd_first", rd_first, 32'd1);
        checkOutput("burst_rd_span", rd_last - rd_first, 32'd15);
        checkOutput("burst_valid_first", v_first, 32'd3);
        checkOutput("burst_valid_span", v_last - v_first, 32'd15);
        checkOutput("burst_overflow", ifc.overflow, 1'b0);

        $display("[TB] backpressure");
        rd_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(c < 16, 8'h80 + 8'(c), 1'b0, 1'b0);
            if (ifc.rd) rd_cnt++;
            step();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("bp_rd_pulses", rd_cnt, 32'd2);
        checkOutput("bp_count14", ifc.count, 32'd14);
        checkOutput("bp_not_full", ifc.full, 1'b0);
        checkOutput("bp_head_held", ifc.m_data, 32'h80);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 8'h90 + 8'(c), 1'b0, 1'b0);
            checkOutput("bp_fill_no_rd", ifc.rd, 1'b0);
            step();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("bp_count16", ifc.count, 32'd16);
        checkOutput("bp_full", ifc.full, 1'b1);
        checkOutput("bp_no_overflow", ifc.overflow, 1'b0);
        checkOutput("bp_head_stable", ifc.m_data, 32'h80);

        applyStimulus(1'b1, 8'h92, 1'b1, 1'b0);
        checkOutput("fs_rd", ifc.rd, 1'b1);
        checkOutput("fs_head", ifc.m_data, 32'h80);
        step();
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("fs_count", ifc.count, 32'd16);
        checkOutput("fs_overflow", ifc.overflow, 1'b0);
        checkOutput("ov_no_rd", ifc.rd, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ov_set", ifc.overflow, 1'b1);
        checkOutput("ov_count", ifc.count, 32'd16);

        out_idx = 0;
        for (int c = 0; c < 60 && out_idx < 18; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            if (ifc.m_valid) begin
                exp_data = 8'h81 + 8'(out_idx);
                checkOutput("drain_data", ifc.m_data, exp_data);
                out_idx++;
            end
            step();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain_words", out_idx, 32'd18);
        checkOutput("drain_empty", ifc.empty, 1'b1);
        checkOutput("drain_valid", ifc.m_valid, 1'b0);
        checkOutput("drain_ov_sticky", ifc.overflow, 1'b1);

        $display("[TB] flush");
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 8'h56, 1'b1, 1'b0);
        checkOutput("clr_pre_rd", ifc.rd, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("clr_rd_low", ifc.rd, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("clr_count", ifc.count, 32'd0);
        checkOutput("clr_valid", ifc.m_valid, 1'b0);
        checkOutput("clr_overflow", ifc.overflow, 1'b0);
        checkOutput("clr_empty", ifc.empty, 1'b1);
        spurious = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            if (ifc.m_valid || ifc.rd) spurious++;
            step();
        end
        checkOutput("clr_no_spurious", spurious, 32'd0);

        $display("[TB] async reset mid-burst");
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 8'h20 + 8'(c), 1'b1, 1'b0);
            step();
        end
        applyStimulus(1'b1, 8'h25, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("ar_count", ifc.count, 32'd0);
        checkOutput("ar_empty", ifc.empty, 1'b1);
        checkOutput("ar_full", ifc.full, 1'b0);
        checkOutput("ar_overflow", ifc.overflow, 1'b0);
        checkOutput("ar_valid", ifc.m_valid, 1'b0);
        checkOutput("ar_data", ifc.m_data, 32'h0);
        checkOutput("ar_rd", ifc.rd, 1'b0);
        ifc.wr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        singleWord();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
